// File: rtl/skyking_input_conditioner_pkg.sv
// Shared widths, event record and priority helper for skyking_input_conditioner.
package skyking_input_pkg;

  localparam int NUM_INPUTS = 8;
  localparam int EVT_W      = 4;

  typedef struct packed {
    logic       pol;
    logic [2:0] idx;
  } evt_t;

  // Index of the lowest set bit; 0 when the vector is empty.
  function automatic logic [2:0] lowest_set_idx(input logic [NUM_INPUTS-1:0] vec);
    logic [2:0] idx;
    idx = 3'd0;
    for (int i = NUM_INPUTS - 1; i >= 0; i--) begin
      if (vec[i]) begin
        idx = 3'(i);
      end else begin
        idx = idx;
      end
    end
    return idx;
  endfunction

endpackage

// File: rtl/skyking_input_conditioner_debounce.sv
// skyking_debounce_bit: 2-flop synchronizer plus debounced stable level for one pin.
// Counters exist only when SKYKING_DEBOUNCE_EN is defined; otherwise stable follows the synchronizer.
module skyking_debounce_bit #(
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_ena,
  input  logic i_pin,
  output logic o_stable
);

  logic r_s1;
  logic r_s2;
  logic r_stable;

  // Two-flop synchronizer, free-running regardless of enable.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s1 <= 1'b0;
      r_s2 <= 1'b0;
    end else begin
      r_s1 <= i_pin;
      r_s2 <= r_s1;
    end
  end

`ifdef SKYKING_DEBOUNCE_EN
  localparam logic [7:0] LP_CNT_LAST = 8'(DEBOUNCE_CYCLES - 1);

  logic [7:0] r_cnt;

  // Count consecutive disagreeing cycles; flip stable on the last one.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt    <= 8'd0;
      r_stable <= 1'b0;
    end else if (!i_ena) begin
      r_cnt <= 8'd0;
    end else if (r_s2 != r_stable) begin
      if (r_cnt == LP_CNT_LAST) begin
        r_stable <= r_s2;
        r_cnt    <= 8'd0;
      end else begin
        r_cnt <= r_cnt + 8'd1;
      end
    end else begin
      r_cnt <= 8'd0;
    end
  end
`else
  // DEBOUNCE_CYCLES has no effect without the counters.
  logic [7:0] w_unused_cfg;
  assign w_unused_cfg = 8'(DEBOUNCE_CYCLES);

  // Stable loads the same value s2 is loading, so a level lands one edge after capture.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_stable <= 1'b0;
    end else if (i_ena) begin
      r_stable <= r_s1;
    end else begin
      r_stable <= r_stable;
    end
  end
`endif

  assign o_stable = r_stable;

endmodule

// File: rtl/skyking_input_conditioner.sv
// Input front-end: per-pin synchronize/debounce, edge-to-event pending bits and an event FIFO.
// Optional debounce counters are built when SKYKING_DEBOUNCE_EN is defined.
module skyking_input_conditioner
  import skyking_input_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int FIFO_DEPTH      = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  ena,
  input  logic [NUM_INPUTS-1:0] ui_in,
  output logic [NUM_INPUTS-1:0] btn_level,
  output logic                  evt_valid,
  input  logic                  evt_ready,
  output logic [EVT_W-1:0]      evt_data,
  output logic                  evt_lost,
  input  logic                  evt_lost_clr
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);

  logic [NUM_INPUTS-1:0] w_stable;
  logic [NUM_INPUTS-1:0] r_stable_d;
  logic [NUM_INPUTS-1:0] w_flip;
  logic [NUM_INPUTS-1:0] r_pending;
  logic [NUM_INPUTS-1:0] r_pend_pol;
  logic [NUM_INPUTS-1:0] w_push_mask;
  logic [NUM_INPUTS-1:0] w_kept;
  logic [NUM_INPUTS-1:0] w_pending_nxt;
  logic [NUM_INPUTS-1:0] w_pol_nxt;
  logic [NUM_INPUTS-1:0] w_cancel;
  logic [2:0]            w_push_idx;
  logic                  w_push;
  logic                  w_pop;
  logic                  w_empty;
  logic                  w_full;
  logic [PTR_W:0]        r_wr_ptr;
  logic [PTR_W:0]        r_rd_ptr;
  evt_t                  r_mem [FIFO_DEPTH];

  for (genvar gi = 0; gi < NUM_INPUTS; gi++) begin : g_bit
    skyking_debounce_bit #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_deb (
      .clk      (clk),
      .rst_n    (rst_n),
      .i_ena    (ena),
      .i_pin    (ui_in[gi]),
      .o_stable (w_stable[gi])
    );
  end

  assign btn_level = w_stable;

  // Delayed copy of stable: a flip is seen one cycle after it happens.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_stable_d <= '0;
    end else begin
      r_stable_d <= w_stable;
    end
  end

  assign w_flip     = w_stable ^ r_stable_d;
  assign w_empty    = (r_wr_ptr == r_rd_ptr);
  assign w_full     = (r_wr_ptr[PTR_W] != r_rd_ptr[PTR_W]) &&
                      (r_wr_ptr[PTR_W-1:0] == r_rd_ptr[PTR_W-1:0]);
  assign evt_valid  = !w_empty;
  assign w_pop      = evt_valid && evt_ready;
  assign w_push     = (|r_pending) && (!w_full || w_pop);
  assign w_push_idx = lowest_set_idx(r_pending);
  assign evt_data   = evt_valid ? r_mem[r_rd_ptr[PTR_W-1:0]] : {EVT_W{1'b0}};

  // One-hot of the pending bit leaving for the FIFO this cycle.
  always_comb begin
    w_push_mask = '0;
    if (w_push) begin
      w_push_mask[w_push_idx] = 1'b1;
    end else begin
      w_push_mask = '0;
    end
  end

  assign w_kept = r_pending & ~w_push_mask;

  // A flip on a bit still waiting cancels it; otherwise it arms a new event.
  always_comb begin
    w_pending_nxt = w_kept;
    w_pol_nxt     = r_pend_pol;
    w_cancel      = '0;
    for (int i = 0; i < NUM_INPUTS; i++) begin
      case ({w_flip[i], w_kept[i]})
        2'b11: begin
          w_pending_nxt[i] = 1'b0;
          w_cancel[i]      = 1'b1;
        end
        2'b10: begin
          w_pending_nxt[i] = 1'b1;
          w_pol_nxt[i]     = w_stable[i];
        end
        default: begin
          w_cancel[i] = 1'b0;
        end
      endcase
    end
  end

  // Pending bits, their polarity and the sticky loss flag (set beats clear).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pending  <= '0;
      r_pend_pol <= '0;
      evt_lost   <= 1'b0;
    end else begin
      r_pending  <= w_pending_nxt;
      r_pend_pol <= w_pol_nxt;
      if (|w_cancel) begin
        evt_lost <= 1'b1;
      end else if (evt_lost_clr) begin
        evt_lost <= 1'b0;
      end else begin
        evt_lost <= evt_lost;
      end
    end
  end

  // FIFO storage and pointers; the extra pointer bit separates full from empty.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        r_mem[i] <= '0;
      end
    end else begin
      if (w_push) begin
        r_mem[r_wr_ptr[PTR_W-1:0]] <= evt_t'{pol: r_pend_pol[w_push_idx], idx: w_push_idx};
        r_wr_ptr                   <= r_wr_ptr + {{PTR_W{1'b0}}, 1'b1};
      end else begin
        r_wr_ptr <= r_wr_ptr;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + {{PTR_W{1'b0}}, 1'b1};
      end else begin
        r_rd_ptr <= r_rd_ptr;
      end
    end
  end

endmodule

// File: tb/tb_skyking_input_conditioner.sv
// Self-checking bench for skyking_input_conditioner: directed scenarios plus random traffic,
// every cycle compared against a queue-based reference model. Honours SKYKING_DEBOUNCE_EN.
module tb_skyking_input_conditioner;

  localparam int DEPTH = 4;
  localparam int NDEB  = 4;
`ifdef SKYKING_DEBOUNCE_EN
  localparam int LAT_LVL = NDEB + 1;
`else
  localparam int LAT_LVL = 1;
`endif
  localparam int LAT_EVT = LAT_LVL + 2;

  logic       clk          = 1'b0;
  logic       rst_n        = 1'b0;
  logic       ena          = 1'b1;
  logic       evt_ready    = 1'b1;
  logic       evt_lost_clr = 1'b0;
  logic [7:0] ui_in        = 8'h00;
  logic [7:0] btn_level;
  logic       evt_valid;
  logic [3:0] evt_data;
  logic       evt_lost;

  int n_assert = 0;
  int n_fail   = 0;

  // reference model state
  logic [7:0] m_smp1, m_smp2, m_stable, m_flip, m_pend, m_pol;
  int         m_run [8];
  logic [3:0] m_q [$];
  logic       m_lost;

  logic [3:0] exp6 [6] = '{4'h8, 4'h1, 4'hA, 4'h3, 4'hC, 4'h5};
  logic [3:0] exp4 [4] = '{4'h0, 4'h9, 4'hB, 4'h4};

  always #5 clk = ~clk;

  skyking_input_conditioner #(.DEBOUNCE_CYCLES(NDEB), .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n), .ena(ena), .ui_in(ui_in), .btn_level(btn_level),
    .evt_valid(evt_valid), .evt_ready(evt_ready), .evt_data(evt_data),
    .evt_lost(evt_lost), .evt_lost_clr(evt_lost_clr)
  );

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] expv);
    n_assert++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  task automatic model_reset();
    m_smp1 = '0; m_smp2 = '0; m_stable = '0; m_flip = '0; m_pend = '0; m_pol = '0;
    m_lost = 1'b0;
    m_q.delete();
    for (int i = 0; i < 8; i++) m_run[i] = 0;
  endtask

  // One clock edge of the behavioural model, using the inputs applied before the edge.
  task automatic model_edge();
    bit pop, space, cancel;
    logic [7:0] nxt;
    pop   = (m_q.size() != 0) && evt_ready;
    space = (m_q.size() < DEPTH) || pop;
    if (pop) void'(m_q.pop_front());
    if (m_pend != 8'h00 && space) begin
      for (int i = 0; i < 8; i++) begin
        if (m_pend[i]) begin
          m_q.push_back({m_pol[i], 3'(i)});
          m_pend[i] = 1'b0;
          break;
        end
      end
    end
    cancel = 1'b0;
    for (int i = 0; i < 8; i++) begin
      if (m_flip[i] && m_pend[i]) begin
        m_pend[i] = 1'b0;
        cancel    = 1'b1;
      end else if (m_flip[i]) begin
        m_pend[i] = 1'b1;
        m_pol[i]  = m_stable[i];
      end
    end
    if (cancel) m_lost = 1'b1;
    else if (evt_lost_clr) m_lost = 1'b0;
    nxt = m_stable;
    for (int i = 0; i < 8; i++) begin
      if (!ena) begin
        m_run[i] = 0;
      end else begin
`ifdef SKYKING_DEBOUNCE_EN
        if (m_smp2[i] != m_stable[i]) begin
          m_run[i]++;
          if (m_run[i] == NDEB) begin
            nxt[i]   = m_smp2[i];
            m_run[i] = 0;
          end
        end else begin
          m_run[i] = 0;
        end
`else
        nxt[i] = m_smp1[i];
`endif
      end
    end
    m_flip   = nxt ^ m_stable;
    m_stable = nxt;
    m_smp2   = m_smp1;
    m_smp1   = ui_in;
  endtask

  task automatic chk_model();
    logic [3:0] exp_d;
    exp_d = (m_q.size() != 0) ? m_q[0] : 4'h0;
    chk("btn_level", btn_level, m_stable);
    chk("evt_valid", {7'b0, evt_valid}, {7'b0, m_q.size() != 0});
    chk("evt_data", {4'h0, evt_data}, {4'h0, exp_d});
    chk("evt_lost", {7'b0, evt_lost}, {7'b0, m_lost});
  endtask

  task automatic step();
    @(posedge clk);
    if (rst_n) model_edge();
    #1;
    chk_model();
  endtask

  // Bounded wait for the head event (ready assumed high), then consume it.
  task automatic expect_evt(input string tag, input logic [3:0] expv);
    int c;
    c = 0;
    while (!evt_valid && c < 40) begin
      step();
      c++;
    end
    chk({tag, "_valid"}, {7'b0, evt_valid}, 8'h01);
    chk(tag, {4'h0, evt_data}, {4'h0, expv});
    step();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("rst_btn_level", btn_level, 8'h00);
    chk("rst_evt_valid", {7'b0, evt_valid}, 8'h00);
    chk("rst_evt_data", {4'h0, evt_data}, 8'h00);
    chk("rst_evt_lost", {7'b0, evt_lost}, 8'h00);
    rst_n = 1'b1;
    repeat (3) step();

    // single press on bit 3: latency of level and event
    ui_in[3] = 1'b1;
    for (int j = 0; j <= LAT_EVT; j++) begin
      step();
      if (j == LAT_LVL - 1) chk("lvl3_early", {7'b0, btn_level[3]}, 8'h00);
      if (j == LAT_LVL)     chk("lvl3_on", {7'b0, btn_level[3]}, 8'h01);
      if (j == LAT_EVT - 1) chk("evt3_early", {7'b0, evt_valid}, 8'h00);
      if (j == LAT_EVT) begin
        chk("evt3_valid", {7'b0, evt_valid}, 8'h01);
        chk("evt3_data", {4'h0, evt_data}, 8'h0B);
      end
    end
    repeat (4) step();

`ifdef SKYKING_DEBOUNCE_EN
    ui_in[0] = 1'b1;
    repeat (3) step();
    ui_in[0] = 1'b0;
    repeat (LAT_EVT + 4) begin
      step();
      chk("glitch_no_evt", {7'b0, evt_valid}, 8'h00);
      chk("glitch_lvl0", {7'b0, btn_level[0]}, 8'h00);
    end
`else
    ui_in[7] = 1'b1;
    step();
    ui_in[7] = 1'b0;
    expect_evt("glitch_press", 4'hF);
    expect_evt("glitch_release", 4'h7);
`endif
    repeat (3) step();

    // bits 5 and 1 together: index order, consecutive cycles
    ui_in = ui_in | 8'h22;
    expect_evt("two_first", 4'h9);
    chk("two_consec", {7'b0, evt_valid}, 8'h01);
    expect_evt("two_second", 4'hD);
    repeat (3) step();

    // six edges under backpressure: four queued, two held pending
    evt_ready = 1'b0;
    ui_in = ui_in ^ 8'h3F;
    repeat (LAT_EVT + 8) step();
    chk("bp_head", {4'h0, evt_data}, 8'h08);
    evt_ready = 1'b1;
    for (int e = 0; e < 6; e++) expect_evt("bp_drain", exp6[e]);
    chk("bp_no_loss", {7'b0, evt_lost}, 8'h00);
    repeat (3) step();

    // fill FIFO, then bit 2 toggles twice while waiting: event lost
    evt_ready = 1'b0;
    ui_in = ui_in ^ 8'h1B;
    repeat (LAT_EVT + 6) step();
    ui_in[2] = 1'b0;
    repeat (LAT_LVL + 4) step();
    ui_in[2] = 1'b1;
    repeat (LAT_LVL + 4) step();
    chk("loss_set", {7'b0, evt_lost}, 8'h01);
    evt_ready = 1'b1;
    for (int e = 0; e < 4; e++) expect_evt("loss_drain", exp4[e]);
    repeat (6) step();
    chk("loss_no_bit2", {7'b0, evt_valid}, 8'h00);
    evt_lost_clr = 1'b1;
    step();
    evt_lost_clr = 1'b0;
    chk("loss_clr", {7'b0, evt_lost}, 8'h00);

    // random traffic
    for (int n = 0; n < 400; n++) begin
      int b;
      b = $urandom_range(7);
      if ($urandom_range(3) == 0) ui_in[b] = ~ui_in[b];
      evt_ready    = ($urandom_range(2) != 0);
      ena          = ($urandom_range(7) != 0);
      evt_lost_clr = ($urandom_range(15) == 0);
      step();
    end
    ena = 1'b1;
    evt_lost_clr = 1'b0;

    // asynchronous reset with events queued, pin 4 held high through it
    evt_ready = 1'b0;
    ui_in = ui_in ^ 8'hF0;
    repeat (LAT_EVT + 3) step();
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    chk("arst_btn_level", btn_level, 8'h00);
    chk("arst_evt_valid", {7'b0, evt_valid}, 8'h00);
    chk("arst_evt_data", {4'h0, evt_data}, 8'h00);
    chk("arst_evt_lost", {7'b0, evt_lost}, 8'h00);
    ui_in = 8'h10;
    repeat (2) step();
    rst_n = 1'b1;
    evt_ready = 1'b1;
    expect_evt("press_after_rst", 4'hC);
    repeat (3) step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
